div_sched: RTL

//   Round-robin scheduler that shares one iterative 64/32 restoring divider

---
 rtl/div_sched.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/div_sched.sv
// ----------------------------------------------------------------------------
// div_sched
//
// Round-robin front end that lets NREQ requesters share one iterative
// 64/32 restoring divider. The winner's operands and id are latched, and
// the divider is started by pulsing its reset. The scheduler then waits for
// fin and returns the result tagged with the requester id. Divide-by-zero is
// answered locally without touching the divider. A divider that never
// finishes is aborted after TMO cycles with an error response.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   req                   one request bit per requester, held until its gnt
//   req_dvdend/req_dvsor  packed per-requester operands
//   gnt                   one-hot single-cycle grant pulse
//   busy                  FSM is not idle
//   rsp_valid             single-cycle response strobe
//   rsp_id/quot/rem       response fields, held until the next response
//   rsp_dz/rsp_err        divide-by-zero / timeout flags
//   div_reset             divider start strobe (also high during reset)
//   div_dvdend/div_dvsor  operands presented to the divider
//   div_fin/quot/rem      divider completion and results
// ----------------------------------------------------------------------------
module div_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int DW   = 32,
   parameter int TMO  = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*2*DW-1:0]   req_dvdend,
   input  logic [NREQ*DW-1:0]     req_dvsor,
   output logic [NREQ-1:0]        gnt,
   output logic                   busy,
   output logic                   rsp_valid,
   output logic [IDW-1:0]         rsp_id,
   output logic [DW-1:0]          rsp_quot,
   output logic [2*DW-1:0]        rsp_rem,
   output logic                   rsp_dz,
   output logic                   rsp_err,
   output logic                   div_reset,
   output logic [2*DW-1:0]        div_dvdend,
   output logic [DW-1:0]          div_dvsor,
   input  logic                   div_fin,
   input  logic [DW-1:0]          div_quot,
   input  logic [2*DW-1:0]        div_rem
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam int TW = $clog2(TMO + 1);

   logic [1:0]      r_state;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_id;
   logic [2*DW-1:0] r_dvdend;
   logic [DW-1:0]   r_dvsor;
   logic [NREQ-1:0] r_gnt;
   logic [TW-1:0]   r_tmo;
   logic [IDW-1:0]  r_rspId;
   logic [DW-1:0]   r_quot;
   logic [2*DW-1:0] r_rem;
   logic            r_dz;
   logic            r_err;

   logic            w_found;
   logic [IDW-1:0]  w_win;
   logic [IDW-1:0]  w_nextPtr;
   logic [2*DW-1:0] w_selDvdend;
   logic [DW-1:0]   w_selDvsor;

   // Index that lies 'offset' positions after 'base', wrapping modulo NREQ.
   // Works for any NREQ, not only powers of two.
   function automatic logic [IDW-1:0] rrIndex(input logic [IDW-1:0] base, input int offset);
      int s;
      s = int'(base) + offset;
      if (s >= NREQ) s = s - NREQ;
      return s[IDW-1:0];
   endfunction

   // Round-robin pick: the first requester at or after the pointer wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req[rrIndex(r_ptr, i)]) begin
            w_found = 1'b1;
            w_win   = rrIndex(r_ptr, i);
         end
      end
   end

   assign w_nextPtr   = rrIndex(w_win, 1);
   assign w_selDvdend = req_dvdend[int'(w_win)*2*DW +: 2*DW];
   assign w_selDvsor  = req_dvsor[int'(w_win)*DW +: DW];

   // Main FSM. Grants are registered, so a grant appears in the cycle after
   // arbitration. That cycle is START for a real divide and RESP for a
   // divide-by-zero, which makes gnt and rsp_valid coincide in the latter.
   // Response fields are only written on the way into RESP, so they hold
   // their last values in between.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_id     <= '0;
         r_dvdend <= '0;
         r_dvsor  <= '0;
         r_gnt    <= '0;
         r_tmo    <= '0;
         r_rspId  <= '0;
         r_quot   <= '0;
         r_rem    <= '0;
         r_dz     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_gnt <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_id     <= w_win;
                  r_dvdend <= w_selDvdend;
                  r_dvsor  <= w_selDvsor;
                  r_ptr    <= w_nextPtr;
                  r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                  if (w_selDvsor == '0) begin
                     r_state <= ST_RESP;
                     r_rspId <= w_win;
                     r_quot  <= '1;
                     r_rem   <= w_selDvdend;
                     r_dz    <= 1'b1;
                     r_err   <= 1'b0;
                  end else begin
                     r_state <= ST_START;
                  end
               end
            end
            ST_START: begin
               r_state <= ST_WAIT;
               r_tmo   <= '0;
            end
            ST_WAIT: begin
               if (div_fin) begin
                  r_state <= ST_RESP;
                  r_rspId <= r_id;
                  r_quot  <= div_quot;
                  r_rem   <= div_rem;
                  r_dz    <= 1'b0;
                  r_err   <= 1'b0;
               end else if (r_tmo == TW'(TMO - 1)) begin
                  r_state <= ST_RESP;
                  r_rspId <= r_id;
                  r_quot  <= '0;
                  r_rem   <= '0;
                  r_dz    <= 1'b0;
                  r_err   <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign busy       = (r_state != ST_IDLE);
   assign rsp_valid  = (r_state == ST_RESP);
   assign rsp_id     = r_rspId;
   assign rsp_quot   = r_quot;
   assign rsp_rem    = r_rem;
   assign rsp_dz     = r_dz;
   assign rsp_err    = r_err;
   // The divider is held in reset while we are, and restarted from START.
   assign div_reset  = reset | (r_state == ST_START);
   assign div_dvdend = r_dvdend;
   assign div_dvsor  = r_dvsor;

endmodule
